panel_switch_bank: RTL and testbench
====================================

PANEL_SWITCH_BANK -- requirements
Module: panel_switch_bank

Interface
REQ-001 SHALL have parameter NUM_SW, default 25: number of front-panel switches.
REQ-002 SHALL have parameter DEBOUNCE, default 16: consecutive stable samples needed to accept a new position; legal range 2..65535.
REQ-003 SHALL have parameter PULSE_LEN, default 4: width of the edge pulse in clk cycles; legal range 1..255.
REQ-004 SHALL have parameter TOGGLE_MASK, NUM_SW bits, default 0: bit i=1 makes switch i a latching toggle.
REQ-005 SHALL provide clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-007 SHALL provide enable  input  1  panel power; 0 forces the reset state every cycle.
REQ-008 SHALL provide sw_in  input  2*NUM_SW  raw position; bits [2i+1:2i] for switch i: 00 center, 01 up, 10 down, 11 invalid.
REQ-009 SHALL provide sw_up  output  NUM_SW  debounced up level.
REQ-010 SHALL provide sw_down  output  NUM_SW  debounced down level.
REQ-011 SHALL provide up_pulse  output  NUM_SW  stretched pulse on entry to up.
REQ-012 SHALL provide down_pulse  output  NUM_SW  stretched pulse on entry to down.
REQ-013 SHALL provide sw_latched  output  NUM_SW  toggle state; 0 for bits with TOGGLE_MASK=0.
REQ-014 SHALL provide any_change  output  1  one-cycle strobe when any debounced position changes.

Function
REQ-015 SHALL register sw_in once per cycle (sample s); an invalid 11 code SHALL be sampled as 00.
REQ-016 Per switch, SHALL keep stable position P (center/up/down), previous sample s_prev, and counter cnt, width clog2(DEBOUNCE).
REQ-017 If s==P: cnt<=0.
REQ-018 If s!=P and s!=s_prev: cnt<=0 (restart).
REQ-019 If s!=P, s==s_prev and cnt<DEBOUNCE-1: cnt<=cnt+1.
REQ-020 If s!=P, s==s_prev and cnt==DEBOUNCE-1: P<=s, cnt<=0.
REQ-021 A sw_in value held constant SHALL reach sw_up/sw_down exactly DEBOUNCE+1 rising edges after it is first presented; a change held for fewer edges SHALL have no effect.
REQ-022 A direct up<->down transition SHALL be accepted without passing through center.
REQ-023 sw_up=(P==up) and sw_down=(P==down); both SHALL never be 1 simultaneously.
REQ-024 On the edge where P becomes up, up_pulse[i] SHALL assert and stay high for exactly PULSE_LEN cycles; down_pulse behaves the same for down.
REQ-025 A new entry into the same position while its pulse is active SHALL restart the pulse at full length.
REQ-026 Leaving the position during an active pulse SHALL NOT truncate the pulse.
REQ-027 Up and down pulse timers SHALL be independent, so both pulses may overlap.
REQ-028 For TOGGLE_MASK[i]=1, each entry of P into up SHALL invert sw_latched[i] on the same edge; down and center entries SHALL leave it unchanged.
REQ-029 any_change SHALL be high for one cycle on the edge after any switch's P changes; simultaneous changes on several switches SHALL yield a single one-cycle strobe.
REQ-030 Switches SHALL be fully independent; no state is shared except the any_change OR.

Reset
REQ-031 When reset=1 or enable=0 at an edge: P=center, cnt=0, s=s_prev=00, pulse timers=0, sw_latched=0, all outputs=0.
REQ-032 Reset/enable=0 arriving mid-debounce or mid-pulse SHALL abort it with no residual pulse.
REQ-033 After release, a held sw_in SHALL be treated as a new change and debounced from zero.
REQ-034 reset SHALL take priority over all other inputs; enable=0 behaves identically to reset.

Verification
REQ-035 DEBOUNCE=4, PULSE_LEN=3: switch 0 at 01 held -> sw_up[0]=1 after exactly 5 edges; up_pulse[0] high 3 cycles; any_change one cycle.
REQ-036 DEBOUNCE=4: 01 for 3 edges, then 00 -> sw_up[0] stays 0, no pulse, no any_change.
REQ-037 TOGGLE_MASK=1: three debounced up entries separated by center -> sw_latched[0] sequence 1,0,1; down entries leave it unchanged.
REQ-038 Switch 2 at 11 with P=center -> outputs unchanged; switch 3 driven 01 then 10 held -> up then down accepted directly, overlapping pulses.
REQ-039 Reset asserted 1 cycle into a 3-cycle pulse -> all outputs 0 next edge; reset released with sw_in held 01 -> sw_up after DEBOUNCE+1 edges.
REQ-040 NUM_SW=25, all switches change at once -> all levels update the same edge; single any_change strobe.

Source files
------------

// File: rtl/panel_switch_bank.sv
// panel_switch_bank: debounces a bank of three-position (center/up/down)
// front-panel switches. For each switch it produces debounced up/down
// levels, stretched entry pulses and an optional latching toggle. A
// bank-wide any_change strobe fires when any switch changes position.
module panel_switch_bank #(
    parameter int                NUM_SW      = 25,
    parameter int                DEBOUNCE    = 16,
    parameter int                PULSE_LEN   = 4,
    parameter logic [NUM_SW-1:0] TOGGLE_MASK = {NUM_SW{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [2*NUM_SW-1:0]   sw_in,
    output logic [NUM_SW-1:0]     sw_up,
    output logic [NUM_SW-1:0]     sw_down,
    output logic [NUM_SW-1:0]     up_pulse,
    output logic [NUM_SW-1:0]     down_pulse,
    output logic [NUM_SW-1:0]     sw_latched,
    output logic                  any_change
);

    // The counter only has to reach DEBOUNCE-1, so clog2(DEBOUNCE) bits are enough.
    localparam int            CW       = $clog2(DEBOUNCE);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE - 1);
    localparam logic [7:0]    PLS_LOAD = 8'(PULSE_LEN - 1);

    localparam logic [1:0] POS_CENTER = 2'b00;
    localparam logic [1:0] POS_UP     = 2'b01;
    localparam logic [1:0] POS_DOWN   = 2'b10;
    localparam logic [1:0] POS_BAD    = 2'b11;

    // Marks every switch whose stable position is updated on this edge.
    logic [NUM_SW-1:0] accept_vec_s;
    logic              chg_r;
    logic              any_change_r;

    // In enable=0 the panel is unpowered, so it behaves exactly like reset.
    logic              clear_s;
    assign clear_s = reset | ~enable;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        logic [1:0]    raw_s;
        logic [1:0]    samp_s;
        logic [1:0]    prev_r;
        logic [1:0]    pos_r;
        logic [CW-1:0] cnt_r;
        logic [CW-1:0] cnt_nxt_s;
        logic          accept_s;
        logic [7:0]    up_tmr_r;
        logic [7:0]    dn_tmr_r;
        logic          up_pls_r;
        logic          dn_pls_r;
        logic          lat_r;

        assign raw_s  = sw_in[2*i +: 2];
        // The invalid 11 code is treated as center so it can never be accepted.
        assign samp_s = (raw_s == POS_BAD) ? POS_CENTER : raw_s;

        // Debounce decision: compare the sample on this edge with the stable
        // position and with the previously registered sample.
        always_comb begin
            cnt_nxt_s = {CW{1'b0}};
            accept_s  = 1'b0;
            if (samp_s == pos_r) begin
                cnt_nxt_s = {CW{1'b0}};
            end else if (samp_s != prev_r) begin
                cnt_nxt_s = {CW{1'b0}};
            end else if (cnt_r != CNT_MAX) begin
                cnt_nxt_s = cnt_r + CW'(1);
            end else begin
                cnt_nxt_s = {CW{1'b0}};
                accept_s  = 1'b1;
            end
        end

        // Per-switch state: sample history, counter, stable position, pulse timers, toggle latch.
        always_ff @(posedge clk) begin
            if (clear_s) begin
                prev_r   <= POS_CENTER;
                cnt_r    <= {CW{1'b0}};
                pos_r    <= POS_CENTER;
                up_tmr_r <= 8'd0;
                dn_tmr_r <= 8'd0;
                up_pls_r <= 1'b0;
                dn_pls_r <= 1'b0;
                lat_r    <= 1'b0;
            end else begin
                prev_r <= samp_s;
                cnt_r  <= cnt_nxt_s;
                if (accept_s) begin
                    pos_r <= samp_s;
                end else begin
                    pos_r <= pos_r;
                end

                // A fresh entry reloads the timer; leaving the position does not cut it short.
                if (accept_s && (samp_s == POS_UP)) begin
                    up_pls_r <= 1'b1;
                    up_tmr_r <= PLS_LOAD;
                end else if (up_tmr_r != 8'd0) begin
                    up_pls_r <= 1'b1;
                    up_tmr_r <= up_tmr_r - 8'd1;
                end else begin
                    up_pls_r <= 1'b0;
                    up_tmr_r <= 8'd0;
                end

                if (accept_s && (samp_s == POS_DOWN)) begin
                    dn_pls_r <= 1'b1;
                    dn_tmr_r <= PLS_LOAD;
                end else if (dn_tmr_r != 8'd0) begin
                    dn_pls_r <= 1'b1;
                    dn_tmr_r <= dn_tmr_r - 8'd1;
                end else begin
                    dn_pls_r <= 1'b0;
                    dn_tmr_r <= 8'd0;
                end

                // Only switches configured as toggles ever leave zero.
                if (accept_s && (samp_s == POS_UP) && TOGGLE_MASK[i]) begin
                    lat_r <= ~lat_r;
                end else begin
                    lat_r <= lat_r;
                end
            end
        end

        assign accept_vec_s[i] = accept_s;
        assign sw_up[i]        = pos_r[0];
        assign sw_down[i]      = pos_r[1];
        assign up_pulse[i]     = up_pls_r;
        assign down_pulse[i]   = dn_pls_r;
        assign sw_latched[i]   = lat_r;
    end

    // Bank-wide change strobe, one edge after the position update; many
    // simultaneous changes collapse into one strobe.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            chg_r        <= 1'b0;
            any_change_r <= 1'b0;
        end else begin
            chg_r        <= |accept_vec_s;
            any_change_r <= chg_r;
        end
    end

    assign any_change = any_change_r;

endmodule

// File: tb/tb_panel_switch_bank.sv
// Directed bench for panel_switch_bank with DEBOUNCE=4, PULSE_LEN=3 and
// switch 0 configured as a latching toggle.
module tb_panel_switch_bank;

    localparam int NUM_SW = 25;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic [2*NUM_SW-1:0] sw_in;
    logic [NUM_SW-1:0]   sw_up;
    logic [NUM_SW-1:0]   sw_down;
    logic [NUM_SW-1:0]   up_pulse;
    logic [NUM_SW-1:0]   down_pulse;
    logic [NUM_SW-1:0]   sw_latched;
    logic                any_change;

    int n_checks = 0;
    int n_fail   = 0;

    panel_switch_bank #(
        .NUM_SW     (NUM_SW),
        .DEBOUNCE   (4),
        .PULSE_LEN  (3),
        .TOGGLE_MASK(25'h0000001)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .sw_in     (sw_in),
        .sw_up     (sw_up),
        .sw_down   (sw_down),
        .up_pulse  (up_pulse),
        .down_pulse(down_pulse),
        .sw_latched(sw_latched),
        .any_change(any_change)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_sw(input int i, input logic [1:0] code);
        sw_in[2*i +: 2] = code;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        sw_in  = '0;
        tick(2);
        check_val("rst_lvl",  {sw_up, sw_down}, 64'h0);
        check_val("rst_pls",  {up_pulse, down_pulse}, 64'h0);
        check_val("rst_misc", {sw_latched, any_change}, 64'h0);
        reset = 1'b0;
        tick(1);

        // Held up on switch 0: level after exactly 5 edges, 3-cycle pulse, single strobe.
        set_sw(0, 2'b01);
        tick(4);
        check_val("up_early", sw_up, 64'h0);
        tick(1);
        check_val("up_at5",     sw_up, 64'h1);
        check_val("upp_c1",     up_pulse, 64'h1);
        check_val("chg_c0",     any_change, 64'h0);
        check_val("lat_first",  sw_latched, 64'h1);
        tick(1);
        check_val("upp_c2",     up_pulse, 64'h1);
        check_val("chg_c1",     any_change, 64'h1);
        tick(1);
        check_val("upp_c3",     up_pulse, 64'h1);
        check_val("chg_c2",     any_change, 64'h0);
        tick(1);
        check_val("upp_end",    up_pulse, 64'h0);

        // Toggle sequence 1,0,1 on up entries; down entry leaves it alone.
        set_sw(0, 2'b00);
        tick(5);
        check_val("ctr_lvl",   sw_up, 64'h0);
        check_val("ctr_lat",   sw_latched, 64'h1);
        set_sw(0, 2'b01);
        tick(5);
        check_val("up2_lvl",   sw_up, 64'h1);
        check_val("up2_lat",   sw_latched, 64'h0);
        set_sw(0, 2'b00);
        tick(5);
        set_sw(0, 2'b01);
        tick(5);
        check_val("up3_lat",   sw_latched, 64'h1);
        set_sw(0, 2'b10);
        tick(5);
        check_val("dn_lvl",    {sw_up, sw_down}, 64'h1);
        check_val("dn_pls",    down_pulse, 64'h1);
        check_val("dn_lat",    sw_latched, 64'h1);
        set_sw(0, 2'b00);
        tick(5);
        check_val("dn_ctr",    sw_down, 64'h0);
        tick(3);

        // Up held for only 3 edges must leave no trace.
        set_sw(0, 2'b01);
        tick(3);
        set_sw(0, 2'b00);
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check_val("short_glitch", {sw_up, up_pulse, any_change}, 64'h0);
        end

        // Invalid code on switch 2 is seen as center.
        set_sw(2, 2'b11);
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check_val("invalid_code", {sw_up, sw_down, any_change}, 64'h0);
        end
        set_sw(2, 2'b00);

        // Switch 3 goes up, then straight to down; switches 4/5 overlap up and down pulses.
        set_sw(3, 2'b01);
        tick(5);
        check_val("s3_up",    sw_up, 64'h8);
        check_val("s3_upp",   up_pulse, 64'h8);
        set_sw(3, 2'b10);
        set_sw(4, 2'b01);
        set_sw(5, 2'b10);
        tick(4);
        check_val("s3_hold",  sw_up, 64'h8);
        tick(1);
        check_val("s3_dn_up", sw_up, 64'h10);
        check_val("s3_dn",    sw_down, 64'h28);
        check_val("ovl_upp",  up_pulse, 64'h10);
        check_val("ovl_dnp",  down_pulse, 64'h28);
        check_val("ovl_lat",  sw_latched, 64'h1);

        // Reset one cycle into a pulse, then re-debounce the held input.
        sw_in = '0;
        set_sw(0, 2'b01);
        tick(5);
        check_val("rp_upp1",  up_pulse, 64'h1);
        tick(1);
        check_val("rp_upp2",  up_pulse, 64'h1);
        reset = 1'b1;
        tick(1);
        check_val("rp_lvl",   {sw_up, sw_down}, 64'h0);
        check_val("rp_pls",   {up_pulse, down_pulse}, 64'h0);
        check_val("rp_misc",  {sw_latched, any_change}, 64'h0);
        reset = 1'b0;
        tick(4);
        check_val("rel_early", sw_up, 64'h0);
        check_val("rel_nopls", up_pulse, 64'h0);
        tick(1);
        check_val("rel_up",   sw_up, 64'h1);
        check_val("rel_upp",  up_pulse, 64'h1);
        check_val("rel_lat",  sw_latched, 64'h1);
        tick(3);
        check_val("rel_quiet", {up_pulse, any_change}, 64'h0);

        // All 25 switches move to down together.
        sw_in = {25{2'b10}};
        tick(4);
        check_val("all_early", sw_down, 64'h0);
        tick(1);
        check_val("all_dn",   sw_down, 64'h1FFFFFF);
        check_val("all_up",   sw_up, 64'h0);
        check_val("all_dnp",  down_pulse, 64'h1FFFFFF);
        check_val("all_chg0", any_change, 64'h0);
        tick(1);
        check_val("all_chg1", any_change, 64'h1);
        tick(1);
        check_val("all_chg2", any_change, 64'h0);

        // Power off behaves as reset, then inputs are re-debounced.
        enable = 1'b0;
        tick(1);
        check_val("off_lvl",  {sw_up, sw_down}, 64'h0);
        check_val("off_pls",  {up_pulse, down_pulse}, 64'h0);
        check_val("off_misc", {sw_latched, any_change}, 64'h0);
        enable = 1'b1;
        tick(4);
        check_val("on_early", sw_down, 64'h0);
        tick(1);
        check_val("on_dn",    sw_down, 64'h1FFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
